// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared sizing constants and FSM state type for the
//                16-to-4 priority encoder slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  // Number of request lines and width of the encoded index
  localparam int N_LINES = 16;
  localparam int IDX_W   = 4;

  // Grant FSM: waiting for an eligible line, or holding a grant until ack
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : enc_pkg
`default_nettype wire

// File: rtl/prio_scan16.sv
`default_nettype none
// ============================================================================
//  Module      : prio_scan16
//  Description : Combinational winner search. Scans vec starting at bit
//                'start' and moving downward with wrap-around
//                (start, start-1, ..., 0, N-1, ...). Reports the first set bit.
//                A start of N-1 gives plain highest-bit-wins priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_scan16 #(
  parameter int N_LINES = enc_pkg::N_LINES,
  parameter int IDX_W   = enc_pkg::IDX_W
) (
  input  logic [N_LINES-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] w_pos;

  // First set bit walking down from start; the index arithmetic wraps at N
  always_comb begin
    idx   = '0;
    found = 1'b0;
    w_pos = '0;
    for (int i = 0; i < N_LINES; i++) begin
      w_pos = start - IDX_W'(i);
      if (!found && vec[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule : prio_scan16
`default_nettype wire

// File: rtl/priority_encoder16to4.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder16to4
//  Description : Registered 16-line priority encoder with request capture,
//                per-line mask, global enable and a valid/ack grant handshake.
//                Optional round-robin arbitration is enabled by defining
//                PRIO_ENC_ROUND_ROBIN_EN; otherwise line 15 always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder16to4 #(
  parameter int N_LINES = enc_pkg::N_LINES,
  parameter int IDX_W   = enc_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] req,
  input  logic [N_LINES-1:0] mask,
  input  logic               En,
  input  logic               ack,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [N_LINES-1:0] pending
);

  import enc_pkg::*;

  localparam logic [IDX_W-1:0]   c_top_line = IDX_W'(N_LINES - 1);
  localparam logic [N_LINES-1:0] c_one      = N_LINES'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_LINES-1:0]   r_pending;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_valid;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_valid_nxt;

  logic [N_LINES-1:0]   w_elig;
  logic [N_LINES-1:0]   w_clr;
  logic                 w_accept;
  logic [IDX_W-1:0]     w_start;
  logic [IDX_W-1:0]     w_win;
  logic                 w_found;

  assign w_elig   = r_pending & mask;
  // Ack only counts while a grant is actually presented
  assign w_accept = r_valid & ack;
  assign w_clr    = w_accept ? (c_one << r_idx) : '0;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;

  // Rotate pointer: next search starts just below the line last accepted
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= c_top_line;
    else if (w_accept)
      r_ptr <= r_idx - IDX_W'(1);
  end

  assign w_start = r_ptr;
`else
  assign w_start = c_top_line;
`endif

  prio_scan16 #(
    .N_LINES (N_LINES),
    .IDX_W   (IDX_W)
  ) u_scan (
    .vec   (w_elig),
    .start (w_start),
    .idx   (w_win),
    .found (w_found)
  );

  // Pending capture; the set term is OR-ed last so a new request wins over the clear
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pending <= '0;
    else
      r_pending <= (r_pending & ~w_clr) | (req & mask);
  end

  // FSM state and grant registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state logic: grant on eligible pending in IDLE, hold until ack in GRANT
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (En && w_found) begin
          w_state_nxt = GRANT;
          w_idx_nxt   = w_win;
          w_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        w_valid_nxt = 1'b1;
        if (ack) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign valid   = r_valid;
  assign idx     = r_idx;
  assign pending = r_pending;

endmodule : priority_encoder16to4
`default_nettype wire

// File: tb/tb_priority_encoder16to4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_encoder16to4
//  Description : Directed self-checking bench for priority_encoder16to4.
//                The round-robin sequence is exercised only when
//                PRIO_ENC_ROUND_ROBIN_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder16to4;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] mask;
  logic        En;
  logic        ack;
  logic        valid;
  logic [3:0]  idx;
  logic [15:0] pending;

  int tests;
  int fails;

  priority_encoder16to4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (mask),
    .En      (En),
    .ack     (ack),
    .valid   (valid),
    .idx     (idx),
    .pending (pending)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = '0;
    mask  = '0;
    En    = 1'b0;
    ack   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_idx",     32'(idx),     32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    rst_n = 1'b1;

    // Fixed priority: 15 before 0, one idle cycle between grants
    req = 16'h8001; mask = 16'hFFFF; En = 1'b1;
    tick();
    check("fp_capture_pending", 32'(pending), 32'h8001);
    check("fp_capture_valid",   32'(valid),   32'h0);
    req = 16'h0000;
    tick();
    check("fp_grant15_valid", 32'(valid), 32'h1);
    check("fp_grant15_idx",   32'(idx),   32'hF);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("fp_gap_valid",   32'(valid),   32'h0);
    check("fp_gap_pending", 32'(pending), 32'h0001);
    tick();
    check("fp_grant0_valid", 32'(valid), 32'h1);
    check("fp_grant0_idx",   32'(idx),   32'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("fp_end_pending", 32'(pending), 32'h0);
    check("fp_end_valid",   32'(valid),   32'h0);
    tick();
    check("fp_stay_idle", 32'(valid), 32'h0);

    // Masked request never captured
    req = 16'h0010; mask = 16'h0000; En = 1'b1;
    tick();
    tick();
    check("mask_pending", 32'(pending), 32'h0);
    check("mask_valid",   32'(valid),   32'h0);
    // Enable low: captured but not granted
    mask = 16'hFFFF; En = 1'b0;
    tick();
    tick();
    check("en0_pending", 32'(pending), 32'h0010);
    check("en0_valid",   32'(valid),   32'h0);
    En = 1'b1;
    tick();
    check("en1_valid", 32'(valid), 32'h1);
    check("en1_idx",   32'(idx),   32'h4);
    req = 16'h0000; ack = 1'b1;
    tick();
    ack = 1'b0;
    check("en1_clear", 32'(pending), 32'h0);

    // Hold in GRANT against hostile inputs
    req = 16'h0020; mask = 16'hFFFF; En = 1'b1;
    tick();
    tick();
    check("hold_grant_idx", 32'(idx), 32'h5);
    req = 16'hFFFF; En = 1'b0; mask = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_idx",   32'(idx),   32'h5);
      check("hold_valid", 32'(valid), 32'h1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0; req = 16'h0000;
    check("hold_release_valid",   32'(valid),   32'h0);
    check("hold_release_pending", 32'(pending), 32'h0);

    // Set wins over clear in the ack cycle
    req = 16'h0008; mask = 16'hFFFF; En = 1'b1;
    tick();
    tick();
    check("soc_grant_idx", 32'(idx), 32'h3);
    ack = 1'b1;
    tick();
    ack = 1'b0; req = 16'h0000;
    check("soc_pending", 32'(pending), 32'h0008);
    check("soc_gap",     32'(valid),   32'h0);
    tick();
    check("soc_regrant_valid", 32'(valid), 32'h1);
    check("soc_regrant_idx",   32'(idx),   32'h3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("soc_final_pending", 32'(pending), 32'h0);

    // Reset while granting
    req = 16'h0040;
    tick();
    tick();
    check("rg_grant_idx", 32'(idx), 32'h6);
    req = 16'h0004;
    tick();
    check("rg_pending_before", 32'(pending), 32'h0044);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rg_valid",   32'(valid),   32'h0);
    check("rg_idx",     32'(idx),     32'h0);
    check("rg_pending", 32'(pending), 32'h0);
    tick();
    check("rg_recapture_pending", 32'(pending), 32'h0004);
    check("rg_recapture_valid",   32'(valid),   32'h0);
    tick();
    check("rg_regrant_valid", 32'(valid), 32'h1);
    check("rg_regrant_idx",   32'(idx),   32'h2);
    req = 16'h0000; ack = 1'b1;
    tick();
    ack = 1'b0;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    // Round robin: all lines requesting, grants rotate downward and wrap
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 16'hFFFF; mask = 16'hFFFF; En = 1'b1; ack = 1'b1;
    for (int g = 0; g < 17; g++) begin
      logic [3:0] exp_idx;
      int         budget;
      exp_idx = 4'(15 - g);
      budget  = 0;
      while (!valid && budget < 4) begin
        tick();
        budget++;
      end
      check("rr_valid", 32'(valid), 32'h1);
      check("rr_idx",   32'(idx),   32'(exp_idx));
      tick();
    end
    ack = 1'b0; req = 16'h0000;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_priority_encoder16to4
`default_nettype wire

// File: doc/priority_encoder16to4.md
PRIORITY_ENCODER16TO4 -- requirements
Module: priority_encoder16to4

Interface
REQ-001 SHALL have parameter N_LINES, default 16, number of request lines (fixed at 16 for this release).
REQ-002 SHALL have parameter IDX_W, default 4, width of encoded index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  16  level request lines, sampled every cycle.
REQ-006 SHALL have port mask  input  16  per-line enable; 1 = line eligible for grant.
REQ-007 SHALL have port En  input  1  global enable; 0 = no new grant issued.
REQ-008 SHALL have port ack  input  1  consumer accepts current idx.
REQ-009 SHALL have port valid  output  1  idx holds a granted line.
REQ-010 SHALL have port idx  output  4  encoded winning line number.
REQ-011 SHALL have port pending  output  16  registered pending-request vector.

Function
REQ-012 SHALL update each cycle: pending <= (pending & ~clr) | (req & mask); clr = one-hot(idx) when valid & ack, else 0.
REQ-013 SHALL give set priority over clear: req[k] & mask[k] in the ack cycle for idx=k leaves pending[k]=1.
REQ-014 SHALL implement FSM with states IDLE and GRANT.
REQ-015 SHALL, in IDLE with En=1 and |(pending & mask)=1, register the winner into idx, set valid=1, and go to GRANT.
REQ-016 SHALL, in IDLE otherwise, hold valid=0 and keep idx at its last value.
REQ-017 SHALL, in GRANT, hold idx stable and valid=1 regardless of En, mask or req changes until ack=1.
REQ-018 SHALL, in GRANT with ack=1, clear pending[idx], drive valid=0 next cycle, and return to IDLE; back-to-back grants are separated by one cycle with valid=0.
REQ-019 SHALL ignore ack while valid=0.
REQ-020 SHALL have latency 2 cycles from req edge to valid: req sampled at edge t, pending at t, valid/idx at t+1.
REQ-021 SHALL, in fixed-priority mode, select the highest-numbered set bit of pending & mask (line 15 highest).
REQ-022 SHALL never assert valid when pending & mask = 0 at the IDLE decision edge.

Reset
REQ-023 SHALL, on rst_n=0 at a clock edge, set pending=0, valid=0, idx=0, state=IDLE, rotate pointer=15.
REQ-024 SHALL, on reset during GRANT, drop the grant without clearing via ack; req lines still asserted are re-captured on the first cycle after rst_n=1.

Configuration
REQ-025 SHALL support macro PRIO_ENC_ROUND_ROBIN_EN; when undefined, fixed priority per REQ-021 and no pointer register exists.
REQ-026 SHALL, with PRIO_ENC_ROUND_ROBIN_EN defined, scan pending & mask starting at pointer ptr downward (ptr, ptr-1, ..., 0, 15, ...) and grant the first set bit.
REQ-027 SHALL, with PRIO_ENC_ROUND_ROBIN_EN defined, update ptr <= (idx-1) mod 16 on each accepted ack (idx=0 gives ptr=15); ptr is otherwise unchanged.

Structure
REQ-028 SHALL place N_LINES, IDX_W, and the FSM state typedef (IDLE, GRANT) in shared package enc_pkg.
REQ-029 SHALL isolate the combinational winner search (vector plus start pointer in, index plus found flag out) in sub-module prio_scan16.
REQ-030 SHALL keep all registers (pending, state, idx, valid, ptr) in priority_encoder16to4.

Verification
REQ-031 SHALL cover fixed priority: req=16'h8001, mask=16'hFFFF, En=1 -> idx=15 valid; ack -> idx=0 after one valid=0 cycle; pending ends 0.
REQ-032 SHALL cover masking/enable: req=16'h0010 with mask=16'h0000 -> pending stays 0, valid stays 0; with mask=16'hFFFF and En=0 -> pending=16'h0010, valid=0 until En=1.
REQ-033 SHALL cover hold: in GRANT with idx=5, drive req=16'hFFFF, En=0, mask=0 for 10 cycles -> idx=5, valid=1 throughout until ack.
REQ-034 SHALL cover set-over-clear: idx=3 granted, ack with req[3]=1 -> pending[3]=1 and line 3 granted again.
REQ-035 SHALL cover reset mid-GRANT: rst_n=0 for one edge -> valid=0, idx=0, pending=0 next cycle; held req=16'h0004 yields valid, idx=2 two cycles after release.
REQ-036 SHALL cover round robin (macro defined): req=16'hFFFF held -> grant sequence 15, 14, 13, ..., 0, 15.
